cache_mem_system: RTL and testbench

- Byte-addressed memory subsystem: 2-way set-associative, write-back, write-allocate cache in front of a 1 KiB backing main memory.
- Serves one word read or write per request from a 10-bit byte address.
- Hit/miss is reported combinationally; misses are resolved at the next clock edge.
- Top of the cache lab datapath; the processor-side stimulus drives its ports directly.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_mem_system_if.sv | 14 +
 rtl/main_memory.sv | 31 +++
 rtl/cache_mem_system.sv | 74 +++++++
 tb/tb_cache_mem_system.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared widths, address-field positions and the cache line record for the cache subsystem.
// No logic here; imported by the cache top, its memory and its bus interface.
package cache_pkg;
  localparam int ADDR_W          = 10;
  localparam int WORD_W          = 32;
  localparam int TAG_W           = 5;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
  localparam int NUM_SETS        = 2;
  localparam int NUM_WAYS        = 2;
  localparam int MEM_WORDS       = 256;
  localparam int BLK_IDX_W       = TAG_W + 1;

  localparam int TAG_LSB  = 5;
  localparam int SET_BIT  = 4;
  localparam int WORD_LSB = 2;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
    logic [BLOCK_W-1:0] data;
  } cacheLine_t;

  // Memory block number: the word index {tag, set, 2'b00} with the word bits dropped.
  function automatic logic [BLK_IDX_W-1:0] blkIdx(input logic [TAG_W-1:0] tag, input logic setSel);
    return {tag, setSel};
  endfunction
endpackage

// File: rtl/cache_mem_system_if.sv
// Processor-side request/response bus of the cache: one word request, combinational hit and data.
// The requester holds its request stable until hit_miss rises; that is the only backpressure.
interface cache_mem_system_if;
  import cache_pkg::*;

  logic              read_write;
  logic [ADDR_W-1:0] address;
  logic [WORD_W-1:0] write_data;
  logic              hit_miss;
  logic [WORD_W-1:0] read_data;

  modport master (output read_write, address, write_data, input hit_miss, read_data);
  modport slave  (input read_write, address, write_data, output hit_miss, read_data);
endinterface

// File: rtl/main_memory.sv
// Backing store: 256 words, combinational 4-word block read, 4-word block write at the clock edge.
// Reset loads word k with value k; no backpressure, a write always lands on the edge.
module main_memory
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BLK_IDX_W-1:0] rdBlk,
  output logic [BLOCK_W-1:0]   rdData,
  input  logic                 wrEn,
  input  logic [BLK_IDX_W-1:0] wrBlk,
  input  logic [BLOCK_W-1:0]   wrData
);
  logic [WORD_W-1:0] mem [MEM_WORDS];

  always_comb begin
    rdData = '0;
    for (int i = 0; i < WORDS_PER_BLOCK; i++)
      rdData[i*WORD_W +: WORD_W] = mem[{rdBlk, 2'(i)}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MEM_WORDS; k++)
        mem[k] <= WORD_W'(k);
    end else if (wrEn) begin
      for (int i = 0; i < WORDS_PER_BLOCK; i++)
        mem[{wrBlk, 2'(i)}] <= wrData[i*WORD_W +: WORD_W];
    end
  end
endmodule

// File: rtl/cache_mem_system.sv
// 2-way set-associative write-back/write-allocate cache over main_memory; hits answer combinationally.
// A miss refills on the next edge and then hits; the requester holds its request until hit_miss = 1.
module cache_mem_system
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  cache_mem_system_if.slave    bus
);
  cacheLine_t           lines [NUM_SETS][NUM_WAYS];
  logic [NUM_SETS-1:0]  lru;

  logic [TAG_W-1:0]     reqTag;
  logic                 setIdx;
  logic [1:0]           wordSel;
  cacheLine_t           line0, line1, hitLine, victimLine;
  logic                 hit0, hit1, hit, hitWay, victimWay;
  logic                 memWrEn;
  logic [BLOCK_W-1:0]   memRdData;
  logic [WORD_W-1:0]    hitWord;

  always_comb begin
    reqTag  = bus.address[ADDR_W-1:TAG_LSB];
    setIdx  = bus.address[SET_BIT];
    wordSel = bus.address[SET_BIT-1:WORD_LSB];

    line0 = lines[setIdx][0];
    line1 = lines[setIdx][1];
    hit0  = line0.valid && (line0.tag == reqTag);
    hit1  = line1.valid && (line1.tag == reqTag);
    hit   = hit0 || hit1;
    hitWay  = hit1 && !hit0;
    hitLine = hitWay ? line1 : line0;
    hitWord = hitLine.data[{wordSel, 5'b0} +: WORD_W];

    // Fill empty ways first (way 0 before way 1), then evict the LRU way.
    if (!line0.valid)      victimWay = 1'b0;
    else if (!line1.valid) victimWay = 1'b1;
    else                   victimWay = lru[setIdx];
    victimLine = victimWay ? line1 : line0;
    memWrEn    = !hit && victimLine.valid && victimLine.dirty;

    bus.hit_miss  = hit;
    bus.read_data = (hit && !bus.read_write) ? hitWord : '0;
  end

  main_memory uMem (
    .clk    (clk),
    .rst_n  (rst_n),
    .rdBlk  (blkIdx(reqTag, setIdx)),
    .rdData (memRdData),
    .wrEn   (memWrEn),
    .wrBlk  (blkIdx(victimLine.tag, setIdx)),
    .wrData (victimLine.data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++)
          lines[s][w] <= '0;
      lru <= '0;
    end else if (hit) begin
      lru[setIdx] <= ~hitWay;
      if (bus.read_write) begin
        lines[setIdx][hitWay].data[{wordSel, 5'b0} +: WORD_W] <= bus.write_data;
        lines[setIdx][hitWay].dirty <= 1'b1;
      end
    end else begin
      // LRU deliberately untouched: the held request's hit next cycle marks the way MRU.
      lines[setIdx][victimWay] <= '{valid: 1'b1, dirty: 1'b0, tag: reqTag, data: memRdData};
    end
  end
endmodule

// File: tb/tb_cache_mem_system.sv
// Directed bench for cache_mem_system: steps through fills, hits, LRU eviction, write-back and reset.
module tb_cache_mem_system;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  cache_mem_system_if bus ();

  cache_mem_system dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [9:0] addr, input logic [31:0] wd);
    bus.read_write = rw;
    bus.address    = addr;
    bus.write_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.read_write = 1'b0;
    bus.address    = '0;
    bus.write_data = '0;
    #12;
    chk("rst_hit", {31'b0, bus.hit_miss}, 32'd0);
    chk("rst_rdata", bus.read_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read 0x000: cold miss, then hit on word 0 of memory block 0.
    drive(1'b0, 10'h000, 32'd0);
    chk("rd000_miss", {31'b0, bus.hit_miss}, 32'd0);
    chk("rd000_miss_rdata", bus.read_data, 32'd0);
    tick();
    chk("rd000_hit", {31'b0, bus.hit_miss}, 32'd1);
    chk("rd000_data", bus.read_data, 32'h0000_0000);
    chk("s0w0_valid", {31'b0, dut.lines[0][0].valid}, 32'd1);
    chk("s0w0_tag", {27'b0, dut.lines[0][0].tag}, 32'd0);
    // Read 0x00C hits same block: word 3 = 3.
    drive(1'b0, 10'h00C, 32'd0);
    chk("rd00c_data", bus.read_data, 32'h0000_0003);
    tick();

    // Write 0x000: immediate hit, read_data forced 0, block dirtied, memory untouched.
    drive(1'b1, 10'h000, 32'h0000_00FF);
    chk("wr000_hit", {31'b0, bus.hit_miss}, 32'd1);
    chk("wr000_rdata", bus.read_data, 32'd0);
    tick();
    tick();
    chk("s0w0_word0", dut.lines[0][0].data[31:0], 32'h0000_00FF);
    chk("s0w0_dirty", {31'b0, dut.lines[0][0].dirty}, 32'd1);
    chk("mem0_after_wr", dut.uMem.mem[0], 32'h0000_0000);
    drive(1'b0, 10'h000, 32'd0);
    chk("rd000_ff", bus.read_data, 32'h0000_00FF);
    tick();

    // Read 0x200: tag 10000 misses, fills way 1 from memory word 0x80.
    drive(1'b0, 10'h200, 32'd0);
    chk("rd200_miss", {31'b0, bus.hit_miss}, 32'd0);
    tick();
    chk("rd200_hit", {31'b0, bus.hit_miss}, 32'd1);
    chk("rd200_data", bus.read_data, 32'h0000_0080);
    chk("s0w1_tag", {27'b0, dut.lines[0][1].tag}, 32'd16);
    tick();
    drive(1'b0, 10'h000, 32'd0);
    chk("rd000_2way_hit", {31'b0, bus.hit_miss}, 32'd1);
    chk("rd000_2way_data", bus.read_data, 32'h0000_00FF);
    tick();

    // Read 0x300: LRU is way 1 (clean), replaced by tag 11000 without write-back.
    drive(1'b0, 10'h300, 32'd0);
    chk("rd300_miss", {31'b0, bus.hit_miss}, 32'd0);
    tick();
    chk("rd300_data", bus.read_data, 32'h0000_00C0);
    chk("s0w1_tag_c0", {27'b0, dut.lines[0][1].tag}, 32'd24);
    chk("mem0_no_wb", dut.uMem.mem[0], 32'h0000_0000);
    tick();

    // Read 0x200: LRU is now dirty way 0; its block is written back before refill.
    drive(1'b0, 10'h200, 32'd0);
    chk("rd200b_miss", {31'b0, bus.hit_miss}, 32'd0);
    tick();
    chk("mem0_wb", dut.uMem.mem[0], 32'h0000_00FF);
    chk("rd200b_data", bus.read_data, 32'h0000_0080);
    chk("s0w0_tag_80", {27'b0, dut.lines[0][0].tag}, 32'd16);
    chk("s0w0_clean", {31'b0, dut.lines[0][0].dirty}, 32'd0);
    tick();
    chk("rd200b_repeat", bus.read_data, 32'h0000_0080);

    // Set 1, word 3 of block {00000,1}: memory word 7.
    drive(1'b0, 10'h01C, 32'd0);
    chk("rd01c_miss", {31'b0, bus.hit_miss}, 32'd0);
    tick();
    chk("rd01c_data", bus.read_data, 32'h0000_0007);
    tick();

    // Reset in the middle of a miss on set 1.
    drive(1'b0, 10'h230, 32'd0);
    chk("rd230_miss", {31'b0, bus.hit_miss}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_hit", {31'b0, bus.hit_miss}, 32'd0);
    chk("rstmid_valid", {28'b0, dut.lines[0][0].valid, dut.lines[0][1].valid,
                         dut.lines[1][0].valid, dut.lines[1][1].valid}, 32'd0);
    chk("rstmid_mem0", dut.uMem.mem[0], 32'h0000_0000);
    chk("rstmid_lru", {30'b0, dut.lru}, 32'd0);
    tick();
    chk("rstmid_hold", {31'b0, bus.hit_miss}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 10'h000, 32'd0);
    chk("post_rst_miss", {31'b0, bus.hit_miss}, 32'd0);
    tick();
    chk("post_rst_data", bus.read_data, 32'h0000_0000);
    chk("post_rst_hit", {31'b0, bus.hit_miss}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
